// File: rtl/alu_arbiter.sv
// Round-robin arbiter giving NREQ requesters shared access to one 8-bit ALU.
// Define ALU_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest index wins).
module alu_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    req_x,
    input  logic [8*NREQ-1:0]    req_y,
    input  logic [4*NREQ-1:0]    req_funct,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [7:0]           rsp_result,
    output logic                 rsp_cmp,
    output logic                 busy,
    output logic                 alu_en,
    output logic [7:0]           alu_x,
    output logic [7:0]           alu_y,
    output logic [3:0]           alu_funct,
    input  logic [7:0]           alu_result,
    input  logic                 alu_cmp
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [3:0] FUNCT_CMP = 4'b0110;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t         state;
    logic [IDW-1:0] owner;

    logic [7:0]     op_x [NREQ];
    logic [7:0]     op_y [NREQ];
    logic [3:0]     op_f [NREQ];

    logic           win_valid;
    logic [IDW-1:0] win_idx;
    logic           launch;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op_x[gi] = req_x[8*gi +: 8];
            assign op_y[gi] = req_y[8*gi +: 8];
            assign op_f[gi] = req_funct[4*gi +: 4];
        end
    endgenerate

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                win_valid = 1'b1;
                win_idx   = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr;

    // Search starts just past the last winner so it yields to anyone else waiting.
    always_comb begin
        int idx;
        idx       = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!win_valid && req[IDW'(idx)]) begin
                win_valid = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end
`endif

    assign launch = win_valid && ((state == IDLE) || (state == DONE));

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_result <= 8'h00;
            rsp_cmp    <= 1'b0;
            busy       <= 1'b0;
            alu_en     <= 1'b0;
            alu_x      <= 8'h00;
            alu_y      <= 8'h00;
            alu_funct  <= 4'h0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr     <= IDW'(NREQ - 1);
`endif
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            alu_en    <= 1'b0;

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                end
                EXEC: begin
                    state <= DONE;
                    busy  <= 1'b1;
                end
                DONE: begin
                    // alu_funct still holds the finishing op; a new launch below overwrites it afterwards.
                    rsp_valid  <= onehot(owner);
                    rsp_cmp    <= alu_cmp;
                    rsp_result <= (alu_funct == FUNCT_CMP) ? {7'b0, alu_cmp} : alu_result;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (launch) begin
                alu_x     <= op_x[win_idx];
                alu_y     <= op_y[win_idx];
                alu_funct <= op_f[win_idx];
                alu_en    <= 1'b1;
                gnt       <= onehot(win_idx);
                owner     <= win_idx;
                state     <= EXEC;
                busy      <= 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                rr_ptr    <= win_idx;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a registered ALU model on the ALU side.
module tb_alu_arbiter;

    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [8*NREQ-1:0]    req_x;
    logic [8*NREQ-1:0]    req_y;
    logic [4*NREQ-1:0]    req_funct;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rsp_valid;
    logic [7:0]           rsp_result;
    logic                 rsp_cmp;
    logic                 busy;
    logic                 alu_en;
    logic [7:0]           alu_x;
    logic [7:0]           alu_y;
    logic [3:0]           alu_funct;
    logic [7:0]           alu_result;
    logic                 alu_cmp;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_funct  (req_funct),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_cmp    (rsp_cmp),
        .busy       (busy),
        .alu_en     (alu_en),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_funct  (alu_funct),
        .alu_result (alu_result),
        .alu_cmp    (alu_cmp)
    );

    function automatic logic [7:0] alu_fn(input logic [7:0] x, input logic [7:0] y, input logic [3:0] f);
        case (f)
            4'b0101: return x + y;
            4'b0110: return {7'b0, x == y};
            4'b1010: return y[3] ? (x >> y[2:0]) : (x << y[2:0]);
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result <= 8'h00;
            alu_cmp    <= 1'b0;
        end else if (alu_en) begin
            alu_result <= alu_fn(alu_x, alu_y, alu_funct);
            if (alu_funct == 4'b0110)
                alu_cmp <= (alu_x == alu_y);
        end
    end

    int cycle = 0;
    always_ff @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int         idx;
        logic [7:0] res;
        logic       cmp;
    } rsp_t;

    int   total = 0;
    int   bad   = 0;
    int   exp_gnt[$];
    rsp_t exp_rsp[$];
    int   mon_g;
    rsp_t mon_r;

    // Scoreboard: every grant and response the DUT produces is popped and compared in order.
    always @(negedge clk) begin
        if (gnt !== '0) begin
            total++;
            if (exp_gnt.size() == 0) begin
                bad++;
                $display("FAIL gnt_unexpected: got %b, required none", gnt);
            end else begin
                mon_g = exp_gnt.pop_front();
                if (gnt !== NREQ'(1 << mon_g)) begin
                    bad++;
                    $display("FAIL gnt_order: got %b, required %b", gnt, NREQ'(1 << mon_g));
                end
            end
        end
        if (rsp_valid !== '0) begin
            total++;
            if (exp_rsp.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got valid=%b result=%h", rsp_valid, rsp_result);
            end else begin
                mon_r = exp_rsp.pop_front();
                if (rsp_valid !== NREQ'(1 << mon_r.idx) || rsp_result !== mon_r.res || rsp_cmp !== mon_r.cmp) begin
                    bad++;
                    $display("FAIL rsp: got valid=%b result=%h cmp=%b, required valid=%b result=%h cmp=%b",
                             rsp_valid, rsp_result, rsp_cmp, NREQ'(1 << mon_r.idx), mon_r.res, mon_r.cmp);
                end else begin
                    $display("rsp req%0d result=%h cmp=%b", mon_r.idx, rsp_result, rsp_cmp);
                end
            end
        end
    end

    task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y, input logic [3:0] f);
        req_x[8*i +: 8]     = x;
        req_y[8*i +: 8]     = y;
        req_funct[4*i +: 4] = f;
    endtask

    task automatic push_op(input int i, input logic [7:0] res, input logic cmp);
        rsp_t r;
        r.idx = i;
        r.res = res;
        r.cmp = cmp;
        exp_gnt.push_back(i);
        exp_rsp.push_back(r);
    endtask

    // Presents one op, holds it until its grant is seen, then drops the request.
    task automatic issue(input int i, input logic [7:0] x, input logic [7:0] y, input logic [3:0] f,
                         input logic [7:0] res, input logic cmp);
        bit got;
        got = 1'b0;
        @(negedge clk);
        set_op(i, x, y, f);
        req[i] = 1'b1;
        push_op(i, res, cmp);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (gnt[i] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        req[i] = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL gnt_timeout: req%0d got no grant, required one within 40 cycles", i);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (busy === 1'b0 && exp_rsp.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: busy=%b pending=%0d, required idle with 0 pending", busy, exp_rsp.size());
        end
    endtask

    task automatic test_reset();
        req       = '0;
        req_x     = '0;
        req_y     = '0;
        req_funct = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({gnt, rsp_valid, rsp_result, rsp_cmp, busy, alu_en, alu_x, alu_y, alu_funct} !== '0) begin
            bad++;
            $display("FAIL reset_values: got gnt=%b rsp_valid=%b busy=%b alu_en=%b, required all 0",
                     gnt, rsp_valid, busy, alu_en);
        end
        rst_n = 1'b1;
        @(negedge clk);
        set_op(1, 8'h11, 8'h22, 4'b0101);
        req[1] = 1'b1;
        exp_gnt.push_back(1);
        @(negedge clk);
        req[1] = 1'b0;
        total++;
        if (busy !== 1'b1 || alu_en !== 1'b1) begin
            bad++;
            $display("FAIL reset_exec_entry: got busy=%b alu_en=%b, required 1 1", busy, alu_en);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({gnt, rsp_valid, rsp_result, rsp_cmp, busy, alu_en, alu_x, alu_y, alu_funct} !== '0) begin
            bad++;
            $display("FAIL reset_mid_exec: got gnt=%b busy=%b alu_en=%b alu_x=%h, required all 0",
                     gnt, busy, alu_en, alu_x);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        $display("reset test complete");
    endtask

    task automatic test_single();
        @(negedge clk);
        set_op(2, 8'h05, 8'h03, 4'b0101);
        req[2] = 1'b1;
        push_op(2, 8'h08, 1'b0);
        @(negedge clk);
        req[2] = 1'b0;
        total++;
        if (gnt !== 4'b0100 || alu_en !== 1'b1 || alu_x !== 8'h05 || alu_y !== 8'h03 || alu_funct !== 4'b0101) begin
            bad++;
            $display("FAIL single_launch: got gnt=%b alu_en=%b x=%h y=%h f=%b, required 0100 1 05 03 0101",
                     gnt, alu_en, alu_x, alu_y, alu_funct);
        end
        @(negedge clk);
        total++;
        if (gnt !== 4'b0000 || rsp_valid !== 4'b0000 || alu_en !== 1'b0) begin
            bad++;
            $display("FAIL single_exec: got gnt=%b rsp_valid=%b alu_en=%b, required 0000 0000 0", gnt, rsp_valid, alu_en);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 4'b0100) begin
            bad++;
            $display("FAIL single_latency: got rsp_valid=%b, required 0100", rsp_valid);
        end
        drain();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_compare();
        issue(0, 8'h5A, 8'h5A, 4'b0110, 8'h01, 1'b1);
        issue(0, 8'h5A, 8'h5B, 4'b0110, 8'h00, 1'b0);
        drain();
    endtask

    task automatic test_contention();
        int order[5];
        int n_gnt;
        int last_cycle;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < NREQ; i++)
            set_op(i, 8'(8'h10 * (i + 1)), 8'(i + 3), 4'b0101);
        for (int k = 0; k < 5; k++)
            push_op(order[k], 8'(8'h10 * (order[k] + 1) + order[k] + 3), 1'b0);
        req        = 4'b1111;
        n_gnt      = 0;
        last_cycle = 0;
        for (int n = 0; n < 40 && n_gnt < 5; n++) begin
            @(negedge clk);
            if (gnt !== '0) begin
                if (n_gnt > 0) begin
                    total++;
                    if (cycle - last_cycle !== 2) begin
                        bad++;
                        $display("FAIL contention_rate: got %0d cycles between grants, required 2", cycle - last_cycle);
                    end
                end
                last_cycle = cycle;
                n_gnt++;
            end
        end
        req = '0;
        total++;
        if (n_gnt !== 5) begin
            bad++;
            $display("FAIL contention_count: got %0d grants, required 5", n_gnt);
        end
        drain();
    endtask

    task automatic test_shift();
        issue(3, 8'h81, 8'h09, 4'b1010, 8'h40, 1'b0);
        issue(3, 8'h81, 8'h01, 4'b1010, 8'h02, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        bit got;
        got = 1'b0;
        @(negedge clk);
        set_op(1, 8'h0A, 8'h14, 4'b0101);
        req[1] = 1'b1;
        push_op(1, 8'h1E, 1'b0);
        push_op(1, 8'h3C, 1'b0);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (gnt[1] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        // Next op presented while req stays high through EXEC and DONE.
        set_op(1, 8'h0F, 8'h02, 4'b1010);
        @(negedge clk);
        total++;
        if (!got || gnt !== 4'b0000) begin
            bad++;
            $display("FAIL b2b_exec: got first_gnt=%b gnt=%b, required 1 0000", got, gnt);
        end
        @(negedge clk);
        req[1] = 1'b0;
        total++;
        if (gnt !== 4'b0010 || rsp_valid !== 4'b0010) begin
            bad++;
            $display("FAIL b2b_overlap: got gnt=%b rsp_valid=%b, required 0010 0010", gnt, rsp_valid);
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        test_reset();
        test_single();
        test_compare();
        test_contention();
        test_shift();
        test_back_to_back();
        repeat (4) @(negedge clk);
        total++;
        if (exp_gnt.size() !== 0 || exp_rsp.size() !== 0) begin
            bad++;
            $display("FAIL leftover: got %0d grants %0d responses outstanding, required 0 0",
                     exp_gnt.size(), exp_rsp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
